// File: rtl/bcd_defs.sv
`default_nettype none
// ============================================================================
// Module      : bcd_defs (package)
// Description : Shared BCD digit width, maximum digit value and legality check
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_defs;

    localparam int           BCD_DIGIT_W = 4;
    localparam logic [3:0]   BCD_MAX     = 4'd9;

    // A nibble is a legal BCD digit when it does not exceed 9
    function automatic logic is_bcd(input logic [BCD_DIGIT_W-1:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage : bcd_defs
`default_nettype wire

// File: rtl/bcd_incrementer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_incrementer
// Description : Combinational single-digit BCD increment with carry out
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_incrementer
    import bcd_defs::*;
(
    input  logic [BCD_DIGIT_W-1:0] in,
    input  logic                   en,
    output logic [BCD_DIGIT_W-1:0] out,
    output logic                   carry
);

    // Table-driven successor so the digit chain never relies on a binary adder
    always_comb begin
        out   = in;
        carry = 1'b0;
        if (en) begin
            case (in)
                4'd0:    out = 4'd1;
                4'd1:    out = 4'd2;
                4'd2:    out = 4'd3;
                4'd3:    out = 4'd4;
                4'd4:    out = 4'd5;
                4'd5:    out = 4'd6;
                4'd6:    out = 4'd7;
                4'd7:    out = 4'd8;
                4'd8:    out = BCD_MAX;
                4'd9: begin
                    out   = 4'd0;
                    carry = 1'b1;
                end
                // Stored digits are always legal; fall back to zero defensively
                default: out = 4'd0;
            endcase
        end
    end

endmodule : bcd_incrementer
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter
// Description : Multi-digit synchronous decimal counter with load sanitiser,
//               terminal count, wrap pulse, sticky overflow and load error
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter
    import bcd_defs::*;
#(
    parameter int DIGITS = 4
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          load,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] load_val,
    input  logic                          en,
    output logic [BCD_DIGIT_W*DIGITS-1:0] count,
    output logic                          tc,
    output logic                          carry_out,
    output logic                          ovf,
    output logic                          load_err
);

    localparam int CNT_W = BCD_DIGIT_W * DIGITS;

    logic [CNT_W-1:0] count_q,     count_d;
    logic             carry_out_q, carry_out_d;
    logic             ovf_q,       ovf_d;
    logic             load_err_q,  load_err_d;

    logic [CNT_W-1:0] w_inc_out;
    logic [DIGITS:0]  w_chain_en;
    logic [CNT_W-1:0] w_load_clean;
    logic             w_load_bad;
    logic             w_all_nines;

    // Digit 0 is enabled by en; each higher digit is enabled by the carry below
    assign w_chain_en[0] = en;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_incrementer u_inc (
                .in    (count_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .en    (w_chain_en[gi]),
                .out   (w_inc_out[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .carry (w_chain_en[gi+1])
            );
        end
    endgenerate

    // Replace any illegal load digit with zero and flag that a substitution occurred
    always_comb begin
        w_load_clean = '0;
        w_load_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (is_bcd(load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                w_load_clean[i*BCD_DIGIT_W +: BCD_DIGIT_W] = load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            end else begin
                w_load_bad = 1'b1;
            end
        end
    end

    // Terminal count: every stored digit equals 9
    always_comb begin
        w_all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] != BCD_MAX) begin
                w_all_nines = 1'b0;
            end
        end
    end

    // Next-state selection in priority order clr > load > en > hold
    always_comb begin
        count_d     = count_q;
        ovf_d       = ovf_q;
        carry_out_d = 1'b0;
        load_err_d  = 1'b0;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d    = w_load_clean;
            load_err_d = w_load_bad;
            ovf_d      = 1'b0;
        end else if (en) begin
            count_d = w_inc_out;
            // Carry out of the top digit means the whole counter wrapped to zero
            if (w_chain_en[DIGITS]) begin
                carry_out_d = 1'b1;
                ovf_d       = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q     <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            carry_out_q <= carry_out_d;
            ovf_q       <= ovf_d;
            load_err_q  <= load_err_d;
        end
    end

    assign count     = count_q;
    assign tc        = w_all_nines;
    assign carry_out = carry_out_q;
    assign ovf       = ovf_q;
    assign load_err  = load_err_q;

endmodule : bcd_counter
`default_nettype wire

// File: tb/tb_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_counter
// Description : Self-checking bench for bcd_counter (DIGITS=4 and DIGITS=1)
//               against a decimal-integer reference model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        load;
    logic        en;
    logic [15:0] load_val;

    logic [15:0] count4;
    logic        tc4, co4, ovf4, le4;
    logic [3:0]  count1;
    logic        tc1, co1, ovf1, le1;

    always #5 clk = ~clk;

    bcd_counter #(.DIGITS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .en        (en),
        .count     (count4),
        .tc        (tc4),
        .carry_out (co4),
        .ovf       (ovf4),
        .load_err  (le4)
    );

    bcd_counter #(.DIGITS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val[3:0]),
        .en        (en),
        .count     (count1),
        .tc        (tc1),
        .carry_out (co1),
        .ovf       (ovf1),
        .load_err  (le1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: index 0 models DIGITS=4, index 1 models DIGITS=1
    int m_v   [2];
    bit m_ovf [2];
    bit m_co  [2];
    bit m_le  [2];
    int m_nd  [2] = '{4, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r = '0;
        int          x = v;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Advance the decimal model by one clock using the currently driven inputs
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int top = pow10(m_nd[k]) - 1;
            if (!rst_n || clr) begin
                m_v[k] = 0; m_ovf[k] = 0; m_co[k] = 0; m_le[k] = 0;
            end else if (load) begin
                int v = 0;
                bit bad = 0;
                for (int i = 0; i < m_nd[k]; i++) begin
                    int d = int'((load_val >> (4*i)) & 16'hF);
                    if (d > 9) begin d = 0; bad = 1; end
                    v = v + d * pow10(i);
                end
                m_v[k] = v; m_le[k] = bad; m_ovf[k] = 0; m_co[k] = 0;
            end else if (en) begin
                m_le[k] = 0;
                if (m_v[k] == top) begin
                    m_v[k] = 0; m_co[k] = 1; m_ovf[k] = 1;
                end else begin
                    m_v[k] = m_v[k] + 1; m_co[k] = 0;
                end
            end else begin
                m_co[k] = 0; m_le[k] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count4"}, 32'(count4), to_bcd(m_v[0], 4));
        chk({tag, ".tc4"},    32'(tc4),    32'(m_v[0] == 9999));
        chk({tag, ".co4"},    32'(co4),    32'(m_co[0]));
        chk({tag, ".ovf4"},   32'(ovf4),   32'(m_ovf[0]));
        chk({tag, ".le4"},    32'(le4),    32'(m_le[0]));
        chk({tag, ".count1"}, 32'(count1), to_bcd(m_v[1], 1));
        chk({tag, ".tc1"},    32'(tc1),    32'(m_v[1] == 9));
        chk({tag, ".co1"},    32'(co1),    32'(m_co[1]));
        chk({tag, ".ovf1"},   32'(ovf1),   32'(m_ovf[1]));
        chk({tag, ".le1"},    32'(le1),    32'(m_le[1]));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic r, input logic c, input logic l, input logic e, input logic [15:0] lv);
        rst_n = r; clr = c; load = l; en = e; load_val = lv;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 0; m_ovf[k] = 0; m_co[k] = 0; m_le[k] = 0;
        end

        // Reset dominates load and en
        cycle("reset");
        cycle("reset2");
        chk("reset.count_const", 32'(count4), 32'h0000);

        // Load 0098 then count through the digit carry
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0098);
        cycle("ld0098");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cycle("inc0099");
        chk("inc0099.const", 32'(count4), 32'h0099);
        cycle("inc0100");
        chk("inc0100.const", 32'(count4), 32'h0100);
        cycle("inc0101");
        chk("inc0101.const", 32'(count4), 32'h0101);

        // Wrap from all nines
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h9998);
        cycle("ld9998");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cycle("inc9999");
        chk("inc9999.tc_const", 32'(tc4), 32'h1);
        cycle("wrap");
        chk("wrap.co_const", 32'(co4), 32'h1);
        chk("wrap.ovf_const", 32'(ovf4), 32'h1);
        cycle("postwrap");
        chk("postwrap.co_const", 32'(co4), 32'h0);

        // Illegal digits sanitised on load
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h3C5F);
        cycle("ld3C5F");
        chk("ld3C5F.count_const", 32'(count4), 32'h3050);
        chk("ld3C5F.le_const", 32'(le4), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        cycle("hold");

        // clr beats a wrap in the same cycle
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h9999);
        cycle("ld9999");
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
        cycle("clrwrap");
        chk("clrwrap.co_const", 32'(co4), 32'h0);

        // Single-digit instance counts 1..9 then wraps on the tenth enable
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        for (int i = 1; i <= 10; i++) begin
            cycle($sformatf("d1run%0d", i));
            chk($sformatf("d1run%0d.co_const", i), 32'(co1), 32'(i == 10));
        end

        // Randomised traffic, biased toward near-wrap loads
        for (int n = 0; n < 600; n++) begin
            int r = int'($urandom_range(0, 99));
            logic [15:0] lv;
            case ($urandom_range(0, 3))
                0:       lv = 16'(32'h9990 + $urandom_range(0, 9));
                1:       lv = 16'($urandom);
                2:       lv = 16'h9999;
                default: lv = to_bcd(int'($urandom_range(0, 9999)), 4)[15:0];
            endcase
            drive((r >= 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 8)  ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                  lv);
            cycle($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bcd_counter
`default_nettype wire

// File: doc/bcd_counter.md
# bcd_counter

Synchronous multi-digit decimal counter built from a chain of `bcd_incrementer` stages, one per digit. The block registers the digit values, ripples each stage's `carry` into the next stage's `en`, and adds load, clear, terminal-count and overflow handling. It sits directly downstream of `bcd_incrementer` and is the counting core for the display and timer blocks.

## Interface

Parameters:
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `clr`, input, 1: synchronous clear of count and flags.
- `load`, input, 1: synchronous parallel load from `load_val`.
- `load_val`, input, 4*DIGITS: load value; digit i is bits [4i+3:4i].
- `en`, input, 1: count enable; increments by one per cycle while high.
- `count`, output, 4*DIGITS: registered counter value, one BCD digit per nibble.
- `tc`, output, 1: terminal count; combinational, high when every digit of `count` is 9.
- `carry_out`, output, 1: registered one-cycle pulse on wrap from all-9s to all-0s.
- `ovf`, output, 1: sticky overflow flag, set on wrap.
- `load_err`, output, 1: registered one-cycle pulse when a load contained a non-BCD digit.

## Operation

- Reset (`rst_n`=0): `count`=0, `carry_out`=0, `ovf`=0, `load_err`=0. `tc`=0 follows from `count`.
- Per-cycle priority: `rst_n` > `clr` > `load` > `en` > hold.
- `clr`=1:
  - `count` goes to 0.
  - `ovf`, `carry_out` and `load_err` go to 0.
- `load`=1:
  - Each digit of `load_val` with value ≤9 is loaded as-is.
  - Each digit with value 10–15 is loaded as 0.
  - `load_err`=1 for one cycle if any digit was replaced.
  - `ovf` is cleared.
  - `carry_out`=0.
  - `en` is ignored in the same cycle.
- `en`=1 with no higher-priority input:
  - Digit 0 incrementer gets `en`=1.
  - The incrementer for digit i>0 gets `en` = digit i-1 `carry`.
  - `count` takes the chained incrementer outputs.
- Wrap: when `en`=1 and `count` is all 9s:
  - `count` goes to 0.
  - `carry_out`=1 for that one cycle.
  - `ovf` is set to 1 and stays 1 until `clr`, `load` or reset.
- `en`=0: `count` and `ovf` hold; `carry_out` and `load_err` go to 0.
- Stored digits are always ≤9. Incrementers never see illegal input.
- Arithmetic: no binary addition anywhere. The digit chain is the only increment path.

## Timing

- Increment latency is 1 cycle: `en` sampled at edge N, new `count` visible after edge N.
- `carry_out` is asserted in the same cycle that `count` reads all-0s after a wrap.
- `tc` is combinational from `count`. A downstream cascade enable is `en & tc` in the same cycle.
- Load latency is 1 cycle. `load_err` is coincident with the loaded `count`.
- `clr` or `load` in the wrap cycle takes priority: no `carry_out`, no `ovf` set.
- Reset asserted mid-count: all outputs are 0 after that edge regardless of other inputs.
- After reset deassertion, the first increment needs `en` sampled at the next edge.

## Structure

- Shared package/include `bcd_defs`:
  - `BCD_DIGIT_W`=4.
  - `BCD_MAX`=4'd9.
  - Function `is_bcd(nibble)`.
- Sub-module: reuse the existing `bcd_incrementer` (combinational `in`, `en`, `out`, `carry`), instantiated DIGITS times in a generate loop.
- Top level holds:
  - The count register.
  - The load sanitiser.
  - The `ovf`/`carry_out`/`load_err` flops.
  - The all-9s detect for `tc`.

## Test plan

- Reset with `en`=1, `load`=1 held → `count`=0x0000, `tc`=0, `ovf`=0, `carry_out`=0, `load_err`=0.
- Load 0x0098, then `en`=1 for 3 cycles → `count` 0x0099, 0x0100, 0x0101; `carry_out` stays 0.
- Load 0x9998, `en`=1 for 3 cycles → `count` 0x9999 (`tc`=1), 0x0000 (`carry_out`=1, `ovf`=1), 0x0001 (`carry_out`=0, `ovf`=1).
- Load 0x3C5F → `count`=0x3050, `load_err`=1 for one cycle, `ovf` cleared.
- Load 0x9999; next cycle `en`=1 and `clr`=1 together → `count`=0x0000, `carry_out`=0, `ovf`=0.
- DIGITS=1: from 0, `en`=1 for 10 cycles → counts 1…9 then 0; `carry_out` pulses on the tenth cycle only.
